// File: rtl/huffman_mcu_scheduler.sv
// Feeds Y/Cb/Cr blocks of each MCU to a Huffman encoder and tracks DC predictors.
// Define JPEG_420_EN for the 4:2:0 slot order (Y,Y,Y,Y,Cb,Cr); default is 4:4:4 (Y,Cb,Cr).
module huffman_mcu_scheduler (
    input  logic         clock,
    input  logic         reset,
    input  logic         frame_start,
    input  logic [15:0]  mcu_total,
    input  logic         y_valid,
    input  logic [511:0] y_pix,
    output logic         y_ready,
    input  logic         cb_valid,
    input  logic [511:0] cb_pix,
    output logic         cb_ready,
    input  logic         cr_valid,
    input  logic [511:0] cr_pix,
    output logic         cr_ready,
    output logic         huff_start,
    output logic [511:0] huff_pix,
    output logic [11:0]  huff_dc_diff,
    output logic         huff_table_sel,
    output logic [1:0]   huff_comp,
    input  logic         huff_done,
    output logic         mcu_done,
    output logic         frame_done,
    output logic [15:0]  mcu_count,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, WAIT_BLK, START, BUSY} state_t;

`ifdef JPEG_420_EN
    localparam logic [2:0] LAST_SLOT = 3'd5;

    function automatic logic [1:0] slot_comp(input logic [2:0] s);
        if (s < 3'd4)       slot_comp = 2'd0;
        else if (s == 3'd4) slot_comp = 2'd1;
        else                slot_comp = 2'd2;
    endfunction
`else
    localparam logic [2:0] LAST_SLOT = 3'd2;

    function automatic logic [1:0] slot_comp(input logic [2:0] s);
        if (s == 3'd0)      slot_comp = 2'd0;
        else if (s == 3'd1) slot_comp = 2'd1;
        else                slot_comp = 2'd2;
    endfunction
`endif

    state_t       state_q, state_d;
    logic [2:0]   slot_q, slot_d;
    logic [15:0]  total_q, total_d;
    logic [15:0]  count_q, count_d;
    logic [7:0]   pred_y_q, pred_y_d;
    logic [7:0]   pred_cb_q, pred_cb_d;
    logic [7:0]   pred_cr_q, pred_cr_d;
    logic [2:0]   ready_q, ready_d;
    logic         start_q, start_d;
    logic [511:0] pix_q, pix_d;
    logic [11:0]  diff_q, diff_d;
    logic         sel_q, sel_d;
    logic [1:0]   comp_q, comp_d;
    logic         mdone_q, mdone_d;
    logic         fdone_q, fdone_d;
    logic         busy_q, busy_d;

    logic [1:0]   cur_comp;
    logic [1:0]   next_comp;
    logic         sel_valid;
    logic [511:0] sel_pix;
    logic [7:0]   cur_pred;
    logic         hs;

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        total_d   = total_q;
        count_d   = count_q;
        pred_y_d  = pred_y_q;
        pred_cb_d = pred_cb_q;
        pred_cr_d = pred_cr_q;
        start_d   = 1'b0;
        pix_d     = pix_q;
        diff_d    = diff_q;
        sel_d     = sel_q;
        comp_d    = comp_q;
        mdone_d   = 1'b0;
        fdone_d   = 1'b0;
        ready_d   = 3'b000;
        next_comp = 2'd0;

        cur_comp = slot_comp(slot_q);
        case (cur_comp)
            2'd0: begin
                sel_valid = y_valid;
                sel_pix   = y_pix;
                cur_pred  = pred_y_q;
            end
            2'd1: begin
                sel_valid = cb_valid;
                sel_pix   = cb_pix;
                cur_pred  = pred_cb_q;
            end
            default: begin
                sel_valid = cr_valid;
                sel_pix   = cr_pix;
                cur_pred  = pred_cr_q;
            end
        endcase
        // ready_q is only ever set for the selected component
        hs = sel_valid && (ready_q != 3'b000);

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    total_d   = mcu_total;
                    pred_y_d  = 8'd0;
                    pred_cb_d = 8'd0;
                    pred_cr_d = 8'd0;
                    slot_d    = 3'd0;
                    count_d   = 16'd0;
                    if (mcu_total == 16'd0) fdone_d = 1'b1;
                    else                    state_d = WAIT_BLK;
                end
            end
            WAIT_BLK: begin
                if (hs) begin
                    pix_d   = sel_pix;
                    diff_d  = {{4{sel_pix[7]}}, sel_pix[7:0]}
                            - {{4{cur_pred[7]}}, cur_pred};
                    comp_d  = cur_comp;
                    sel_d   = (cur_comp != 2'd0);
                    start_d = 1'b1;
                    state_d = START;
                    case (cur_comp)
                        2'd0:    pred_y_d  = sel_pix[7:0];
                        2'd1:    pred_cb_d = sel_pix[7:0];
                        default: pred_cr_d = sel_pix[7:0];
                    endcase
                end
            end
            START: state_d = BUSY;
            BUSY: begin
                if (huff_done) begin
                    if (slot_q == LAST_SLOT) begin
                        slot_d  = 3'd0;
                        count_d = count_q + 16'd1;
                        mdone_d = 1'b1;
                        if (count_q + 16'd1 == total_q) begin
                            fdone_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_BLK;
                        end
                    end else begin
                        slot_d  = slot_q + 3'd1;
                        state_d = WAIT_BLK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == WAIT_BLK) begin
            next_comp = slot_comp(slot_d);
            case (next_comp)
                2'd0:    ready_d = 3'b001;
                2'd1:    ready_d = 3'b010;
                default: ready_d = 3'b100;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            slot_q    <= 3'd0;
            total_q   <= 16'd0;
            count_q   <= 16'd0;
            pred_y_q  <= 8'd0;
            pred_cb_q <= 8'd0;
            pred_cr_q <= 8'd0;
            ready_q   <= 3'b000;
            start_q   <= 1'b0;
            pix_q     <= '0;
            diff_q    <= 12'd0;
            sel_q     <= 1'b0;
            comp_q    <= 2'd0;
            mdone_q   <= 1'b0;
            fdone_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            total_q   <= total_d;
            count_q   <= count_d;
            pred_y_q  <= pred_y_d;
            pred_cb_q <= pred_cb_d;
            pred_cr_q <= pred_cr_d;
            ready_q   <= ready_d;
            start_q   <= start_d;
            pix_q     <= pix_d;
            diff_q    <= diff_d;
            sel_q     <= sel_d;
            comp_q    <= comp_d;
            mdone_q   <= mdone_d;
            fdone_q   <= fdone_d;
            busy_q    <= busy_d;
        end
    end

    assign y_ready        = ready_q[0];
    assign cb_ready       = ready_q[1];
    assign cr_ready       = ready_q[2];
    assign huff_start     = start_q;
    assign huff_pix       = pix_q;
    assign huff_dc_diff   = diff_q;
    assign huff_table_sel = sel_q;
    assign huff_comp      = comp_q;
    assign mcu_done       = mdone_q;
    assign frame_done     = fdone_q;
    assign mcu_count      = count_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_huffman_mcu_scheduler.sv
// Directed bench for huffman_mcu_scheduler; expected slot order follows JPEG_420_EN.
module tb_huffman_mcu_scheduler;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         frame_start = 1'b0;
    logic [15:0]  mcu_total = 16'd0;
    logic         y_valid = 1'b0, cb_valid = 1'b0, cr_valid = 1'b0;
    logic [511:0] y_pix = '0, cb_pix = '0, cr_pix = '0;
    logic         y_ready, cb_ready, cr_ready;
    logic         huff_start;
    logic [511:0] huff_pix;
    logic [11:0]  huff_dc_diff;
    logic         huff_table_sel;
    logic [1:0]   huff_comp;
    logic         huff_done = 1'b0;
    logic         mcu_done, frame_done, busy;
    logic [15:0]  mcu_count;

`ifdef JPEG_420_EN
    localparam int NSLOT = 6;
    localparam int SEQ [6] = '{0, 0, 0, 0, 1, 2};
`else
    localparam int NSLOT = 3;
    localparam int SEQ [3] = '{0, 1, 2};
`endif

    int n_checks = 0;
    int n_pass = 0;
    int n_starts = 0;

    huffman_mcu_scheduler dut (
        .clock(clock), .reset(reset),
        .frame_start(frame_start), .mcu_total(mcu_total),
        .y_valid(y_valid), .y_pix(y_pix), .y_ready(y_ready),
        .cb_valid(cb_valid), .cb_pix(cb_pix), .cb_ready(cb_ready),
        .cr_valid(cr_valid), .cr_pix(cr_pix), .cr_ready(cr_ready),
        .huff_start(huff_start), .huff_pix(huff_pix),
        .huff_dc_diff(huff_dc_diff), .huff_table_sel(huff_table_sel),
        .huff_comp(huff_comp), .huff_done(huff_done),
        .mcu_done(mcu_done), .frame_done(frame_done),
        .mcu_count(mcu_count), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (huff_start) n_starts++;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic rdy(input int c);
        if (c == 0) return y_ready;
        if (c == 1) return cb_ready;
        return cr_ready;
    endfunction

    function automatic logic [511:0] mk_pix(input int c, input logic [7:0] dc);
        logic [511:0] p;
        for (int k = 1; k < 64; k++) p[8*k +: 8] = 8'(c * 40 + k);
        p[7:0] = dc;
        return p;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_y_ready"}, y_ready, 0);
        chk({tag, "_cb_ready"}, cb_ready, 0);
        chk({tag, "_cr_ready"}, cr_ready, 0);
        chk({tag, "_huff_start"}, huff_start, 0);
        chk({tag, "_huff_pix_zero"}, huff_pix == '0, 1);
        chk({tag, "_dc_diff"}, huff_dc_diff, 0);
        chk({tag, "_table_sel"}, huff_table_sel, 0);
        chk({tag, "_comp"}, huff_comp, 0);
        chk({tag, "_mcu_done"}, mcu_done, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_mcu_count"}, mcu_count, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic start_frame(input logic [15:0] n);
        frame_start = 1'b1;
        mcu_total = n;
        step();
        frame_start = 1'b0;
    endtask

    task automatic do_block(input int c, input logic [7:0] dc, input int diff,
                            input bit send_done);
        logic [511:0] p;
        int waitn;
        p = mk_pix(c, dc);
        waitn = 0;
        if (c == 0) begin y_pix = p; y_valid = 1'b1; end
        else if (c == 1) begin cb_pix = p; cb_valid = 1'b1; end
        else begin cr_pix = p; cr_valid = 1'b1; end
        while (!rdy(c) && waitn < 40) begin
            step();
            waitn++;
        end
        chk("ready_wait", waitn < 40, 1);
        step();
        y_valid = 1'b0;
        cb_valid = 1'b0;
        cr_valid = 1'b0;
        chk("huff_start", huff_start, 1);
        chk("huff_comp", huff_comp, c);
        chk("table_sel", huff_table_sel, c != 0);
        chk("dc_diff", huff_dc_diff, diff & 'hfff);
        chk("huff_pix", huff_pix == p, 1);
        if (send_done) begin
            step();
            chk("start_one_cycle", huff_start, 0);
            chk("comp_stable", huff_comp, c);
            step();
            step();
            huff_done = 1'b1;
            step();
            huff_done = 1'b0;
        end
    endtask

    task automatic run_mcu(input logic [7:0] ydc, input logic [7:0] cbdc,
                           input logic [7:0] crdc, input int ydiff,
                           input int cbdiff, input int crdiff);
        bit first_y;
        first_y = 1'b1;
        for (int s = 0; s < NSLOT; s++) begin
            if (SEQ[s] == 0) begin
                do_block(0, ydc, first_y ? ydiff : 0, 1'b1);
                first_y = 1'b0;
            end else if (SEQ[s] == 1) begin
                do_block(1, cbdc, cbdiff, 1'b1);
            end else begin
                do_block(2, crdc, crdiff, 1'b1);
            end
            if (s < NSLOT - 1) chk("mcu_done_early", mcu_done, 0);
        end
    endtask

    initial begin
        int s0;

        reset = 1'b1;
        step();
        step();
        chk_zero("reset");
        reset = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        start_frame(16'd0);
        chk("zero_frame_done", frame_done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_y_ready", y_ready, 0);
        step();
        chk("zero_frame_done_off", frame_done, 0);
        chk("zero_busy2", busy, 0);
        chk("zero_y_ready2", y_ready, 0);

        s0 = n_starts;
        start_frame(16'd1);
        chk("f1_busy", busy, 1);
        chk("f1_y_ready", y_ready, 1);
        cb_pix = mk_pix(1, 8'h55);
        cr_pix = mk_pix(2, 8'h66);
        cb_valid = 1'b1;
        cr_valid = 1'b1;
        huff_done = 1'b1;
        step();
        huff_done = 1'b0;
        step();
        step();
        chk("ign_cb_ready", cb_ready, 0);
        chk("ign_cr_ready", cr_ready, 0);
        chk("ign_y_ready", y_ready, 1);
        chk("ign_no_start", huff_start, 0);
        cb_valid = 1'b0;
        cr_valid = 1'b0;
        run_mcu(8'd10, 8'hFD, 8'd5, 10, -3, 5);
        chk("f1_mcu_done", mcu_done, 1);
        chk("f1_frame_done", frame_done, 1);
        chk("f1_mcu_count", mcu_count, 1);
        chk("f1_busy_end", busy, 0);
        chk("f1_nstarts", n_starts - s0, NSLOT);
        step();
        chk("f1_mcu_done_off", mcu_done, 0);
        chk("f1_frame_done_off", frame_done, 0);
        chk("f1_count_hold", mcu_count, 1);

        start_frame(16'd2);
        chk("f2_count_clear", mcu_count, 0);
        frame_start = 1'b1;
        mcu_total = 16'd5;
        step();
        frame_start = 1'b0;
        run_mcu(8'd10, 8'd0, 8'd0, 10, 0, 0);
        chk("f2_mcu_done1", mcu_done, 1);
        chk("f2_frame_done1", frame_done, 0);
        chk("f2_count1", mcu_count, 1);
        chk("f2_y_ready", y_ready, 1);
        run_mcu(8'd7, 8'd0, 8'd0, -3, 0, 0);
        chk("f2_mcu_done2", mcu_done, 1);
        chk("f2_frame_done2", frame_done, 1);
        chk("f2_count2", mcu_count, 2);
        step();
        step();
        chk("f2_count_hold", mcu_count, 2);
        chk("f2_idle", busy, 0);

        start_frame(16'd1);
        do_block(0, 8'd20, 20, 1'b0);
        step();
        chk("rb_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_zero("rb_after_reset");
        huff_done = 1'b1;
        step();
        huff_done = 1'b0;
        chk_zero("rb_done_ignored");
        step();
        chk("rb_no_mcu_done", mcu_done, 0);
        chk("rb_idle", busy, 0);
        start_frame(16'd1);
        run_mcu(8'd20, 8'd1, 8'd2, 20, 1, 2);
        chk("rb_frame_done", frame_done, 1);
        chk("rb_count", mcu_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/huffman_mcu_scheduler.md
HUFFMAN_MCU_SCHEDULER -- requirements
Module: huffman_mcu_scheduler

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: clock  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 SHALL have these frame-control inputs:
- frame_start  in  1  one-cycle pulse that begins a frame.
- mcu_total  in  16  number of MCUs in the frame, sampled on frame_start.
REQ-003 SHALL have these block-source ports, with c in {y, cb, cr}:
- c_valid  in  1  block available.
- c_pix  in  512  64 zigzag coefficients, 8-bit signed, coefficient k at [8k+7:8k], DC at [7:0].
- c_ready  out  1  accept.
REQ-004 SHALL have these Huffman-encoder ports:
- huff_start  out  1  one-cycle start pulse.
- huff_pix  out  512  registered block.
- huff_dc_diff  out  12  signed DC difference.
- huff_table_sel  out  1  0=luma, 1=chroma.
- huff_comp  out  2  0=Y, 1=Cb, 2=Cr.
- huff_done  in  1  one-cycle encoder completion pulse.
REQ-005 SHALL have these status outputs:
- mcu_done  out  1  one-cycle pulse per completed MCU.
- frame_done  out  1  one-cycle pulse per completed frame.
- mcu_count  out  16  MCUs completed in the current frame.
- busy  out  1  high in every state except IDLE.

Function
REQ-006 SHALL implement a four-state FSM: IDLE, WAIT_BLK, START, BUSY.
REQ-007 IDLE:
- On frame_start, latch mcu_total, clear all three DC predictors to 0, clear slot and mcu_count to 0, go to WAIT_BLK.
- If the latched mcu_total==0, pulse frame_done in the next cycle instead and stay in IDLE.
REQ-008 SHALL walk an MCU slot sequence, with slot as a counter over that sequence (see REQ-020); the slot's component selects which c_ready is asserted.
REQ-009 WAIT_BLK:
- Exactly the selected component's c_ready SHALL be 1; all other c_ready SHALL be 0.
- On selected c_valid && c_ready: register c_pix into huff_pix, set huff_comp and huff_table_sel (Y=0, Cb/Cr=1), go to START.
REQ-010 DC arithmetic:
- huff_dc_diff = sext12(current DC) - sext12(predictor of that component), registered together with huff_pix.
- The predictor is updated to the current DC in the same cycle.
- Range -255..+255, no saturation.
REQ-011 START: assert huff_start for exactly one cycle, go to BUSY. huff_pix, huff_dc_diff, huff_comp and huff_table_sel SHALL stay stable from START until leaving BUSY.
REQ-012 BUSY: wait for huff_done. On huff_done:
- If the slot is not last: slot+1, go to WAIT_BLK.
- If the slot is last: slot=0, mcu_count+1, mcu_done=1 in the following cycle.
- If the incremented mcu_count equals mcu_total: frame_done=1 in the same cycle as mcu_done, go to IDLE; otherwise go to WAIT_BLK.
REQ-013 Ignored events:
- c_valid on a non-selected component; it SHALL NOT be consumed.
- huff_done outside BUSY.
- frame_start outside IDLE.
REQ-014 Latency: block handshake to huff_start is 1 cycle. huff_done to the next c_ready is 1 cycle. huff_done to mcu_done is 1 cycle.
REQ-015 mcu_count SHALL hold its final value after frame_done until the next accepted frame_start.
REQ-016 c_ready SHALL depend only on registered state, never combinationally on c_valid.

Reset
REQ-017 On reset, at any point including mid-block: state=IDLE.
REQ-018 On reset, every output SHALL be 0: all c_ready, huff_start, huff_pix, huff_dc_diff, huff_table_sel, huff_comp, mcu_done, frame_done, mcu_count, busy.
REQ-019 On reset, predictors, slot and latched mcu_total SHALL be 0. A huff_done arriving after reset SHALL be ignored.

Configuration
REQ-020 Macro JPEG_420_EN selects the MCU slot sequence:
- Defined: 4:2:0 sequence Y,Y,Y,Y,Cb,Cr (6 slots, slot counter wraps 5 to 0).
- Undefined: 4:4:4 sequence Y,Cb,Cr (3 slots, wraps 2 to 0).
- All other behaviour is identical in both builds.

Verification
REQ-021 SHALL cover these directed scenarios:
- Without the macro, mcu_total=1, Y DC=10, Cb DC=-3, Cr DC=5, huff_done 4 cycles after each huff_start -> huff_comp 0,1,2; huff_dc_diff 10,-3,5; one mcu_done with frame_done; mcu_count=1.
- mcu_total=2, Y DCs 10 then 7 -> second Y huff_dc_diff=-3; predictor persists across MCUs.
- With JPEG_420_EN, mcu_total=1 -> four Y blocks then Cb, Cr; huff_table_sel 0,0,0,0,1,1; exactly six huff_start pulses.
- cb_valid and cr_valid held high while Y is selected -> cb_ready and cr_ready stay 0; no Cb/Cr block consumed until its slot.
- Reset asserted in BUSY, then huff_done pulsed -> all outputs 0, IDLE held, no mcu_done; a new frame_start restarts with predictors=0.
- frame_start with mcu_total=0 -> frame_done one cycle later, no c_ready asserted, busy stays 0.
